poly_eval: RTL and testbench

POLY_EVAL -- requirements
Module: poly_eval

---
 rtl/poly_eval_pkg.sv | 24 ++
 rtl/poly_eval_if.sv | 30 +++
 rtl/poly_eval_alu.sv | 31 +++
 rtl/poly_eval.sv | 144 ++++++++++++++
 tb/tb_poly_eval.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types for the polynomial evaluator: FSM states and ALU operations.
package poly_eval_pkg;

   // ST_RLOAD is the load of the leading coefficient entered from reset;
   // ST_LOAD covers every other slot and the return after an evaluation.
   typedef enum logic [2:0] {
      ST_RLOAD = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_MUL   = 3'd3,
      ST_ADD   = 3'd4
   } state_e;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_MUL = 1'b1
   } alu_op_e;

   // Both load states capture data_in identically.
   function automatic logic is_load_state(input state_e s);
      return (s == ST_RLOAD) || (s == ST_LOAD);
   endfunction

endpackage

// File: rtl/poly_eval_if.sv
// Operator-facing bus of the polynomial evaluator.
//
// Handshake: the operator drives go and data_in. go is level-sampled on each
// rising clk edge. In a load slot, data_in is captured on every edge, and the
// first edge that sees go=1 freezes the slot. The slot stays frozen while
// go remains 1. The edge that sees go=0 advances to the next slot; after the
// x slot, that edge starts compute instead. go and data_in are ignored
// during compute. data_result is meaningful while result_valid=1.
interface poly_eval_if #(parameter int W = 8);
   import poly_eval_pkg::*;

   logic         go;
   logic [W-1:0] data_in;
   logic [W-1:0] data_result;
   logic         result_valid;
   logic         busy;
   logic         overflow;
   state_e       dbg_state;

   modport master (
      output go, data_in,
      input  data_result, result_valid, busy, overflow, dbg_state
   );

   modport slave (
      input  go, data_in,
      output data_result, result_valid, busy, overflow, dbg_state
   );

endinterface

// File: rtl/poly_eval_alu.sv
// Combinational add/multiply unit, truncating to W bits. A flag reports when
// the full-width result did not fit.
module poly_eval_alu
   import poly_eval_pkg::*;
#(
   parameter int W = 8
) (
   input  alu_op_e      op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o,
   output logic         ovf_o
);

   logic [2*W-1:0] prod;
   logic [W:0]     sum;

   // Compute both results at full width, then pick one and flag lost upper bits.
   always_comb begin
      prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
      sum  = {1'b0, a_i} + {1'b0, b_i};
      if (op_i == OP_MUL) begin
         y_o   = prod[W-1:0];
         ovf_o = |prod[2*W-1:W];
      end else begin
         y_o   = sum[W-1:0];
         ovf_o = sum[W];
      end
   end

endmodule

// File: rtl/poly_eval.sv
// Sequential Horner evaluator: y = sum a_i * x^i mod 2^W.
// The operator loads a_DEGREE down to a_0, then x. The block then spends one
// MUL and one ADD cycle per remaining coefficient.
module poly_eval
   import poly_eval_pkg::*;
#(
   parameter int W      = 8,
   parameter int DEGREE = 3
) (
   input  logic       clk,
   input  logic       reset,
   poly_eval_if.slave bus
);

   // Slots 0..DEGREE hold a_DEGREE..a_0; slot DEGREE+1 is x.
   localparam int IW = $clog2(DEGREE + 2);
   localparam int CW = $clog2(DEGREE + 1);
   localparam logic [IW-1:0] LAST_COEF = IW'(DEGREE);
   localparam logic [IW-1:0] X_SLOT    = IW'(DEGREE + 1);

   state_e        state_q;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  coef_q [0:DEGREE];
   logic [W-1:0]  x_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  result_q;
   logic          valid_q;
   logic          valid_pend_q;
   logic          busy_q;
   logic          ovf_q;

   logic [CW-1:0] coef_idx;
   alu_op_e       alu_op_d;
   logic [W-1:0]  alu_b_d;
   logic [W-1:0]  alu_y;
   logic          alu_ovf;

   assign coef_idx = idx_q[CW-1:0];

   // Pick the ALU operation from the compute phase. MUL scales by x; ADD
   // folds in the coefficient that the shared index points at.
   always_comb begin
      alu_op_d = OP_ADD;
      alu_b_d  = coef_q[coef_idx];
      if (state_q == ST_MUL) begin
         alu_op_d = OP_MUL;
         alu_b_d  = x_q;
      end
   end

   poly_eval_alu #(.W(W)) u_alu (
      .op_i  (alu_op_d),
      .a_i   (acc_q),
      .b_i   (alu_b_d),
      .y_o   (alu_y),
      .ovf_o (alu_ovf)
   );

   // Operand storage: the current load slot follows data_in every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         coef_q <= '{default: '0};
         x_q    <= '0;
      end else if (is_load_state(state_q)) begin
         if (idx_q == X_SLOT) begin
            x_q <= bus.data_in;
         end else if (idx_q <= LAST_COEF) begin
            coef_q[coef_idx] <= bus.data_in;
         end
      end
   end

   // Control FSM with registered status outputs and the Horner accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RLOAD;
         idx_q        <= '0;
         acc_q        <= '0;
         result_q     <= '0;
         valid_q      <= 1'b0;
         valid_pend_q <= 1'b0;
         busy_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         valid_pend_q <= 1'b0;
         case (state_q)
            ST_RLOAD, ST_LOAD: begin
               if (bus.go) begin
                  state_q <= ST_WAIT;
                  // A new evaluation begins; the old result is no longer current.
                  if (idx_q == '0) valid_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (!bus.go) begin
                  if (idx_q == X_SLOT) begin
                     state_q <= ST_MUL;
                     acc_q   <= coef_q[0];
                     idx_q   <= IW'(1);
                     ovf_q   <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ST_LOAD;
                     idx_q   <= idx_q + IW'(1);
                  end
               end
            end
            ST_MUL: begin
               acc_q   <= alu_y;
               ovf_q   <= ovf_q | alu_ovf;
               state_q <= ST_ADD;
            end
            ST_ADD: begin
               acc_q <= alu_y;
               ovf_q <= ovf_q | alu_ovf;
               if (idx_q == LAST_COEF) begin
                  result_q     <= alu_y;
                  state_q      <= ST_LOAD;
                  idx_q        <= '0;
                  busy_q       <= 1'b0;
                  valid_pend_q <= 1'b1;
               end else begin
                  idx_q   <= idx_q + IW'(1);
                  state_q <= ST_MUL;
               end
            end
            default: begin
               state_q <= ST_RLOAD;
               idx_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
         // result_valid rises one cycle after the final ADD wrote data_result.
         if (valid_pend_q) valid_q <= 1'b1;
      end
   end

   assign bus.data_result  = result_q;
   assign bus.result_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.overflow     = ovf_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_poly_eval.sv
// Bench for poly_eval. It runs a W=8/DEGREE=3 instance through table vectors,
// hand-written corner sequences and random evaluations. A W=16/DEGREE=1
// instance gets a single evaluation.
module tb_poly_eval;
   import poly_eval_pkg::*;

   typedef struct {
      logic [3:0][7:0] a;      // a[i] is a_i
      logic [7:0]      x;
      logic [7:0]      res;
      logic            ovf;
      bit              toggle;  // wiggle go during compute
      int              hold;    // extra cycles go stays high in WAIT(a2)
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [8:0] exp_q[$];
   logic [7:0] last_res;
   vec_t tbl[8];

   poly_eval_if #(.W(8))  bus8 ();
   poly_eval_if #(.W(16)) bus16 ();

   poly_eval #(.W(8),  .DEGREE(3)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
   poly_eval #(.W(16), .DEGREE(1)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Reference model: direct power sum for y. Overflow is tracked by replaying
   // the Horner steps in plain integer arithmetic and testing each against 2^8.
   function automatic logic [8:0] model8(input logic [3:0][7:0] a, input logic [7:0] x);
      longint y = 0;
      longint p = 1;
      longint acc;
      bit     ov = 1'b0;
      for (int i = 0; i < 4; i++) begin
         y = y + longint'(a[i]) * p;
         p = p * longint'(x);
      end
      acc = longint'(a[3]);
      for (int i = 2; i >= 0; i--) begin
         acc = acc * longint'(x);
         if (acc > 255) ov = 1'b1;
         acc = acc % 256;
         acc = acc + longint'(a[i]);
         if (acc > 255) ov = 1'b1;
         acc = acc % 256;
      end
      return {ov, 8'(y % 256)};
   endfunction

   // Driver: load a3..a0 then x. Returns one cycle after the go=0 edge in WAIT(x).
   task automatic load_all8(input vec_t v);
      for (int k = 0; k <= 4; k++) begin
         bus8.data_in = (k == 4) ? v.x : v.a[3-k];
         bus8.go = 1'b1;
         tick();
         if (k == 0) check("valid_clear_on_go", 32'(bus8.result_valid), 0);
         for (int h = 0; h < ((k == 1) ? v.hold : 0); h++) begin
            bus8.data_in = 8'($urandom);
            tick();
         end
         if (k == 1 && v.hold > 0) check("wait_hold_state", 32'(bus8.dbg_state), 32'(ST_WAIT));
         if (k == 4) check("result_retained", 32'(bus8.data_result), 32'(last_res));
         bus8.go = 1'b0;
         bus8.data_in = 8'($urandom);
         tick();
      end
   endtask

   // Full evaluation with latency, busy-length and scoreboard checks.
   task automatic run_eval8(input vec_t v);
      logic [8:0] exp;
      int busy_n;
      int valid_at;
      exp_q.push_back({v.ovf, v.res});
      load_all8(v);
      busy_n = 0;
      valid_at = -1;
      if (bus8.busy) busy_n++;
      for (int n = 1; n <= 20 && valid_at < 0; n++) begin
         bus8.go = (v.toggle && n <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus8.data_in = 8'($urandom);
         tick();
         if (bus8.busy) busy_n++;
         if (bus8.result_valid) valid_at = n;
      end
      bus8.go = 1'b0;
      check("busy_cycles", 32'(busy_n), 6);
      check("valid_latency", 32'(valid_at), 7);
      check("state_after_eval", 32'(bus8.dbg_state), 32'(ST_LOAD));
      exp = exp_q.pop_front();
      check("data_result", 32'(bus8.data_result), 32'(exp[7:0]));
      check("overflow", 32'(bus8.overflow), 32'(exp[8]));
      last_res = exp[7:0];
   endtask

   initial begin
      vec_t rv;
      logic [8:0] m;
      logic [15:0] seq16 [3];
      int busy_n;
      int valid_at;

      tbl[0] = '{a: {8'd1, 8'd2, 8'd3, 8'd4},  x: 8'd2,  res: 8'd26,  ovf: 1'b0, toggle: 1'b0, hold: 0};
      tbl[1] = '{a: {8'd1, 8'd0, 8'd0, 8'd0},  x: 8'd16, res: 8'd0,   ovf: 1'b1, toggle: 1'b0, hold: 0};
      tbl[2] = '{a: {8'd1, 8'd0, 8'd0, 8'd0},  x: 8'd2,  res: 8'd8,   ovf: 1'b0, toggle: 1'b0, hold: 0};
      tbl[3] = '{a: {8'd1, 8'd2, 8'd3, 8'd4},  x: 8'd2,  res: 8'd26,  ovf: 1'b0, toggle: 1'b1, hold: 0};
      tbl[4] = '{a: {8'd0, 8'd0, 8'd0, 8'd200}, x: 8'd77, res: 8'd200, ovf: 1'b0, toggle: 1'b0, hold: 0};
      tbl[5] = '{a: {8'd0, 8'd0, 8'd1, 8'd255}, x: 8'd1,  res: 8'd0,   ovf: 1'b1, toggle: 1'b0, hold: 0};
      tbl[6] = '{a: {8'd0, 8'd0, 8'd16, 8'd0},  x: 8'd16, res: 8'd0,   ovf: 1'b1, toggle: 1'b0, hold: 0};
      tbl[7] = '{a: {8'd5, 8'd9, 8'd0, 8'd3},   x: 8'd3,  res: 8'd219, ovf: 1'b0, toggle: 1'b0, hold: 9};

      // Reset, with go asserted so that reset must win.
      reset = 1'b1;
      bus8.go = 1'b1;
      bus8.data_in = 8'hAA;
      bus16.go = 1'b1;
      bus16.data_in = 16'h55AA;
      repeat (3) tick();
      reset = 1'b0;
      bus8.go = 1'b0;
      bus16.go = 1'b0;
      tick();
      last_res = 8'd0;
      check("rst_state", 32'(bus8.dbg_state), 32'(ST_RLOAD));
      check("rst_result", 32'(bus8.data_result), 0);
      check("rst_valid", 32'(bus8.result_valid), 0);
      check("rst_busy", 32'(bus8.busy), 0);
      check("rst_overflow", 32'(bus8.overflow), 0);
      check("rst16_state", 32'(bus16.dbg_state), 32'(ST_RLOAD));
      check("rst16_result", 32'(bus16.data_result), 0);

      // DEGREE=1, W=16: 300*200 + 7.
      seq16 = '{16'd300, 16'd7, 16'd200};
      for (int k = 0; k < 3; k++) begin
         bus16.data_in = seq16[k];
         bus16.go = 1'b1;
         tick();
         bus16.go = 1'b0;
         bus16.data_in = 16'($urandom);
         tick();
      end
      busy_n = 0;
      valid_at = -1;
      if (bus16.busy) busy_n++;
      for (int n = 1; n <= 20 && valid_at < 0; n++) begin
         tick();
         if (bus16.busy) busy_n++;
         if (bus16.result_valid) valid_at = n;
      end
      check("d1_busy_cycles", 32'(busy_n), 2);
      check("d1_valid_latency", 32'(valid_at), 3);
      check("d1_result", 32'(bus16.data_result), 60007);
      check("d1_overflow", 32'(bus16.overflow), 0);

      // Table vectors
      for (int i = 0; i < 8; i++) run_eval8(tbl[i]);

      // Reset in the third compute cycle aborts the evaluation.
      load_all8(tbl[0]);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_res = 8'd0;
      check("abort_state", 32'(bus8.dbg_state), 32'(ST_RLOAD));
      check("abort_result", 32'(bus8.data_result), 0);
      check("abort_valid", 32'(bus8.result_valid), 0);
      check("abort_busy", 32'(bus8.busy), 0);
      check("abort_overflow", 32'(bus8.overflow), 0);
      for (int n = 0; n < 10; n++) begin
         tick();
         check("abort_valid_idle", 32'(bus8.result_valid), 0);
      end
      run_eval8(tbl[0]);

      // Randomized evaluations against the model
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 4; i++) rv.a[i] = 8'($urandom_range(0, 255));
         if (r < 4) rv.a[3] = 8'($urandom_range(0, 3));
         rv.x = (r < 4) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
         m = model8(rv.a, rv.x);
         rv.res = m[7:0];
         rv.ovf = m[8];
         rv.toggle = 1'($urandom_range(0, 1));
         rv.hold = $urandom_range(0, 3);
         run_eval8(rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
